mvmu_driver: RTL and testbench

//  Command-side initiator for the MVMU crossbar. Accepts clean / load-weights / compute commands,

---
 rtl/mvmu_pkg.sv | 34 +++
 rtl/mvmu_driver_if.sv | 35 +++
 rtl/mvmu_watchdog.sv | 41 ++++
 rtl/mvmu_driver.sv | 220 ++++++++++++++++++++++
 tb/tb_mvmu_driver.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mvmu_pkg.sv
// -----------------------------------------------------------------------------
// mvmu_pkg
// Shared constants for the MVMU command driver:
//   - MVMU web command codes (the values the crossbar decodes on its web bus)
//   - command opcodes carried on cmd_op
//   - driver FSM state encoding (also exported on the driver's dbg_state port)
// -----------------------------------------------------------------------------
package mvmu_pkg;

    // MVMU web bus commands
    localparam logic [3:0] WEB_CLEAN = 4'd0;
    localparam logic [3:0] WEB_WRITE = 4'd1;
    localparam logic [3:0] WEB_PIM   = 4'd2;
    localparam logic [3:0] WEB_NOP   = 4'd3;
    localparam logic [3:0] WEB_PRO   = 4'd4;
    localparam logic [3:0] WEB_IDLE  = 4'd5;

    // cmd_op codes
    localparam logic [1:0] OP_CLEAN   = 2'd0;
    localparam logic [1:0] OP_LOAD    = 2'd1;
    localparam logic [1:0] OP_COMPUTE = 2'd2;
    localparam logic [1:0] OP_RSVD    = 2'd3;

    // Driver FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAN = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PRIME = 3'd3,
        ST_RUN   = 3'd4,
        ST_OUT   = 3'd5
    } state_e;

endpackage

// File: rtl/mvmu_driver_if.sv
// -----------------------------------------------------------------------------
// mvmu_driver_if
// The bus between the command driver and one MVMU crossbar.
//   mvmu_en        driver -> MVMU   MVMU reset/enable (1 = running)
//   mvmu_web       driver -> MVMU   4-bit command (see mvmu_pkg WEB_*)
//   mvmu_addr      driver -> MVMU   weight address of the first byte of a beat
//   mvmu_data      driver -> MVMU   16 weight bytes, byte i lands at addr+i
//   mvmu_pim_in    driver -> MVMU   input vector for a compute
//   mvmu_pro_flag  MVMU -> driver   result ready
//   mvmu_pro_q     MVMU -> driver   result vector
// Modports: master = driver side, slave = MVMU side.
// -----------------------------------------------------------------------------
interface mvmu_driver_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int B_RAM_DEPTH    = 32,
    parameter int NUM_OF_COLUMNS = 32
);
    logic                                mvmu_en;
    logic [3:0]                          mvmu_web;
    logic [15:0]                         mvmu_addr;
    logic [16*DATA_WIDTH-1:0]            mvmu_data;
    logic [DATA_WIDTH*B_RAM_DEPTH-1:0]   mvmu_pim_in;
    logic                                mvmu_pro_flag;
    logic [DATA_WIDTH*NUM_OF_COLUMNS-1:0] mvmu_pro_q;

    modport master (
        output mvmu_en, mvmu_web, mvmu_addr, mvmu_data, mvmu_pim_in,
        input  mvmu_pro_flag, mvmu_pro_q
    );

    modport slave (
        input  mvmu_en, mvmu_web, mvmu_addr, mvmu_data, mvmu_pim_in,
        output mvmu_pro_flag, mvmu_pro_q
    );
endinterface

// File: rtl/mvmu_watchdog.sv
// -----------------------------------------------------------------------------
// mvmu_watchdog
// Counts cycles while `run` is high and flags `expired` on the LIMIT-th such
// cycle. The count returns to zero whenever `run` drops, so every entry into
// the watched state starts from zero.
//   clk, rst_n   clock, asynchronous active-low reset
//   run          high while the watched state is active
//   expired      combinational: high during the LIMIT-th consecutive run cycle
// -----------------------------------------------------------------------------
module mvmu_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q, count_d;

    // count_q holds the number of run cycles already completed.
    assign expired = run && (count_q == CW'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (!run) begin
            count_d = '0;
        end else if (!expired) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/mvmu_driver.sv
// -----------------------------------------------------------------------------
// mvmu_driver
// Command-side initiator for one MVMU crossbar. Accepts clean / load-weights /
// compute commands, sequences the MVMU web/addr/data/pim_in bus, waits for the
// MVMU result flag and returns the result vector on a valid/ready stream.
//
// Handshakes: every stream (cmd, w, res) transfers on a rising clk edge where
// both valid and ready are high; valid must then hold its payload stable until
// that edge, ready may be asserted independently of valid.
//
// Ports
//   clk, RSTn           clock, asynchronous active-low reset
//   cmd_valid/ready     command stream; ready only in IDLE
//   cmd_op              0 clean, 1 load weights, 2 compute, 3 reserved (no-op)
//   cmd_vec             compute input vector, captured on the handshake
//   w_valid/ready/data  weight beats (16 bytes) during a load
//   res_valid/ready     result stream
//   res_data            captured MVMU result
//   res_err             result produced by the RUN watchdog (data is zero)
//   dbg_state           current FSM state (mvmu_pkg::state_e encoding)
//   mvmu                MVMU bus, master side
//
// Build option: define MVMU_TIMEOUT_EN to add a RUN watchdog
// (mvmu_watchdog, TIMEOUT_CYCLES). Without it RUN waits for the flag forever
// and res_err stays 0.
// -----------------------------------------------------------------------------
module mvmu_driver
    import mvmu_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int M_RAM_DEPTH    = 1024,
    parameter int B_RAM_DEPTH    = 32,
    parameter int NUM_OF_COLUMNS = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk,
    input  logic                                 RSTn,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [1:0]                           cmd_op,
    input  logic [DATA_WIDTH*B_RAM_DEPTH-1:0]    cmd_vec,
    input  logic                                 w_valid,
    output logic                                 w_ready,
    input  logic [16*DATA_WIDTH-1:0]             w_data,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [DATA_WIDTH*NUM_OF_COLUMNS-1:0] res_data,
    output logic                                 res_err,
    output logic [2:0]                           dbg_state,
    mvmu_driver_if.master                        mvmu
);
    localparam int BEATS = M_RAM_DEPTH / 16;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VW    = DATA_WIDTH * B_RAM_DEPTH;
    localparam int RW    = DATA_WIDTH * NUM_OF_COLUMNS;

    state_e                   state_q, state_d;
    logic                     en_q;
    logic [3:0]               web_q, web_d;
    logic [15:0]              addr_q, addr_d;
    logic [16*DATA_WIDTH-1:0] data_q, data_d;
    logic [VW-1:0]            pim_in_q, pim_in_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic                     res_valid_q, res_valid_d;
    logic [RW-1:0]            res_data_q, res_data_d;
    logic                     res_err_q, res_err_d;
    logic                     timeout;

    wire cmd_fire = cmd_valid && cmd_ready;
    wire w_fire   = w_valid && w_ready;
    wire res_fire = res_valid_q && res_ready;

    assign cmd_ready = (state_q == ST_IDLE);
    assign w_ready   = (state_q == ST_LOAD);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign dbg_state = state_q;

    assign mvmu.mvmu_en     = en_q;
    assign mvmu.mvmu_web    = web_q;
    assign mvmu.mvmu_addr   = addr_q;
    assign mvmu.mvmu_data   = data_q;
    assign mvmu.mvmu_pim_in = pim_in_q;

`ifdef MVMU_TIMEOUT_EN
    mvmu_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (RSTn),
        .run     (state_q == ST_RUN),
        .expired (timeout)
    );
    assign res_err = res_err_q;
`else
    assign timeout = 1'b0;
    assign res_err = 1'b0;
    // res_err_q can never set in this build; TIMEOUT_CYCLES has no watchdog.
    logic unused_cfg;
    assign unused_cfg = res_err_q ^ (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d     = state_q;
        web_d       = web_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pim_in_d    = pim_in_q;
        beat_d      = beat_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;

        case (state_q)
            ST_IDLE: begin
                web_d = WEB_NOP;
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_CLEAN: begin
                            state_d = ST_CLEAN;
                            web_d   = WEB_CLEAN;
                        end
                        OP_LOAD: begin
                            state_d = ST_LOAD;
                            beat_d  = '0;
                        end
                        OP_COMPUTE: begin
                            // WEB_IDLE for one cycle flushes any stale
                            // progress the MVMU may hold from an aborted run.
                            state_d  = ST_PRIME;
                            web_d    = WEB_IDLE;
                            pim_in_d = cmd_vec;
                        end
                        default: ; // reserved op: accepted, nothing happens
                    endcase
                end
            end

            ST_CLEAN: begin
                state_d = ST_IDLE;
                web_d   = WEB_NOP;
            end

            ST_LOAD: begin
                web_d = WEB_NOP;
                if (w_fire) begin
                    web_d  = WEB_WRITE;
                    addr_d = 16'({beat_q, 4'b0000});
                    data_d = w_data;
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(BEATS - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_PRIME: begin
                state_d = ST_RUN;
                web_d   = WEB_PRO;
            end

            ST_RUN: begin
                web_d = WEB_PRO;
                // A real flag wins over a watchdog expiry in the same cycle.
                if (mvmu.mvmu_pro_flag) begin
                    state_d     = ST_OUT;
                    web_d       = WEB_NOP;
                    res_valid_d = 1'b1;
                    res_data_d  = mvmu.mvmu_pro_q;
                end else if (timeout) begin
                    state_d     = ST_OUT;
                    web_d       = WEB_NOP;
                    res_valid_d = 1'b1;
                    res_data_d  = '0;
                    res_err_d   = 1'b1;
                end
            end

            ST_OUT: begin
                web_d = WEB_NOP;
                if (res_fire) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                web_d   = WEB_NOP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            web_q       <= WEB_NOP;
            addr_q      <= '0;
            data_q      <= '0;
            pim_in_q    <= '0;
            beat_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= 1'b1;
            web_q       <= web_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pim_in_q    <= pim_in_d;
            beat_q      <= beat_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end
endmodule

// File: tb/tb_mvmu_driver.sv
module tb_mvmu_driver;
    localparam int DW    = 8;
    localparam int MD    = 1024;
    localparam int BD    = 32;
    localparam int NC    = 32;
    localparam int TO    = 255;
    localparam int BEATS = MD / 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [DW*BD-1:0]  cmd_vec = '0;
    logic              w_valid = 1'b0;
    logic              w_ready;
    logic [16*DW-1:0]  w_data = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [DW*NC-1:0]  res_data;
    logic              res_err;
    logic [2:0]        dbg_state;

    mvmu_driver_if #(.DATA_WIDTH(DW), .B_RAM_DEPTH(BD), .NUM_OF_COLUMNS(NC)) bus ();

    mvmu_driver #(
        .DATA_WIDTH(DW), .M_RAM_DEPTH(MD), .B_RAM_DEPTH(BD),
        .NUM_OF_COLUMNS(NC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .RSTn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_vec(cmd_vec),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .dbg_state(dbg_state),
        .mvmu(bus)
    );

    // ---------------- MVMU behavioural model (environment) ----------------
    // Row i of the weight matrix holds input element i; column c is result byte c.
    // One column per web=4 cycle, then the flag is registered one cycle later.
    logic [7:0] dev_mem [0:MD-1];
    int         dev_cnt = 0;
    bit         stuck = 1'b0;

    function automatic logic [DW*NC-1:0] dev_product();
        logic [DW*NC-1:0] r;
        int acc;
        for (int c = 0; c < NC; c++) begin
            acc = 0;
            for (int i = 0; i < BD; i++)
                acc += int'(dev_mem[i*NC+c]) * int'(bus.mvmu_pim_in[i*8 +: 8]);
            r[c*8 +: 8] = 8'(acc);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!bus.mvmu_en) begin
            dev_cnt = 0;
            bus.mvmu_pro_flag <= 1'b0;
        end else begin
            case (bus.mvmu_web)
                4'd0: for (int i = 0; i < MD; i++) dev_mem[i] = 8'd0;
                4'd1: for (int i = 0; i < 16; i++)
                          if (int'(bus.mvmu_addr) + i < MD)
                              dev_mem[int'(bus.mvmu_addr) + i] = bus.mvmu_data[i*8 +: 8];
                4'd4: begin
                    if (dev_cnt == NC) begin
                        if (!stuck) begin
                            bus.mvmu_pro_flag <= 1'b1;
                            bus.mvmu_pro_q    <= dev_product();
                        end
                    end else begin
                        dev_cnt++;
                    end
                end
                default: begin
                    dev_cnt = 0;
                    bus.mvmu_pro_flag <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- bus monitor ----------------
    logic [15:0] addr_log[$];
    int          clean_cnt = 0;
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.mvmu_web == 4'd1) addr_log.push_back(bus.mvmu_addr);
            if (bus.mvmu_web == 4'd0) clean_cnt++;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [7:0]  ref_mem [0:MD-1];
    logic [15:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW*NC-1:0] ref_result(input logic [DW*BD-1:0] vec);
        logic [DW*NC-1:0] r;
        int acc;
        for (int c = 0; c < NC; c++) begin
            acc = 0;
            for (int i = 0; i < BD; i++)
                acc += int'(ref_mem[i*NC+c]) * int'(vec[i*8 +: 8]);
            r[c*8 +: 8] = 8'(acc);
        end
        return r;
    endfunction

    function automatic logic [DW*BD-1:0] rand_vec();
        logic [DW*BD-1:0] v;
        for (int i = 0; i < BD; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue_cmd(input logic [1:0] op, input logic [DW*BD-1:0] vec);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_vec   = vec;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // mode 0: byte k = k mod 256, mode 1: all ones, otherwise random
    task automatic load_weights(input int mode);
        int base;
        int wait_n;
        int bad;
        logic [16*DW-1:0] beat;
        logic [7:0] v;
        base = addr_log.size();
        issue_cmd(2'd1, '0);
        for (int b = 0; b < BEATS; b++) begin
            w_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                case (mode)
                    0:       v = 8'(b*16 + i);
                    1:       v = 8'd1;
                    default: v = 8'($urandom_range(0, 15));
                endcase
                ref_mem[b*16 + i] = v;
                beat[i*8 +: 8] = v;
            end
            w_data  = beat;
            w_valid = 1'b1;
            exp_q.push_back(16'(b*16));
            wait_n = 0;
            while (!w_ready && wait_n < 100) begin
                @(negedge clk);
                wait_n++;
            end
            if (!w_ready) begin
                check_val("w_ready_wait", 0, 1);
                break;
            end
            @(negedge clk);
        end
        w_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("load_beat_count", addr_log.size() - base, exp_q.size());
        for (int k = 0; exp_q.size() > 0; k++) begin
            if (base + k < addr_log.size())
                check_val("load_addr", addr_log[base + k], exp_q.pop_front());
            else
                void'(exp_q.pop_front());
        end
        bad = 0;
        for (int i = 0; i < MD; i++) if (dev_mem[i] !== ref_mem[i]) bad++;
        check_val("load_mem_bad_bytes", bad, 0);
        check_val("load_back_idle", cmd_ready, 1'b1);
        check_val("load_w_ready_low", w_ready, 1'b0);
    endtask

    task automatic do_compute(input string tag, input logic [DW*BD-1:0] vec,
                              input logic [DW*NC-1:0] exp_res, input logic exp_err,
                              input int exp_lat, input int hold);
        int unsigned h;
        int waited;
        issue_cmd(2'd2, vec);
        h = cyc;
        check_val({tag, "_prime_web"}, bus.mvmu_web, 4'd5);
        check_val({tag, "_busy"}, cmd_ready, 1'b0);
        @(negedge clk);
        check_val({tag, "_run_web"}, bus.mvmu_web, 4'd4);
        check_val({tag, "_pim_in"}, bus.mvmu_pim_in, vec);
        waited = 0;
        while (!res_valid && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!res_valid) begin
            check_val({tag, "_res_wait"}, 0, 1);
            return;
        end
        check_val({tag, "_latency"}, cyc - h, exp_lat);
        check_val({tag, "_res_data"}, res_data, exp_res);
        check_val({tag, "_res_err"}, res_err, exp_err);
        check_val({tag, "_out_web"}, bus.mvmu_web, 4'd3);
        for (int k = 0; k < hold; k++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom_range(0, 3));
            @(negedge clk);
            check_val({tag, "_hold_valid"}, res_valid, 1'b1);
            check_val({tag, "_hold_data"}, res_data, exp_res);
            check_val({tag, "_hold_cmd_ready"}, cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_val({tag, "_res_cleared"}, res_valid, 1'b0);
        check_val({tag, "_err_cleared"}, res_err, 1'b0);
        check_val({tag, "_idle"}, cmd_ready, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DW*BD-1:0] vec;
        logic [DW*BD-1:0] twos;
        logic [DW*NC-1:0] sixty_fours;
        int c0;
        for (int i = 0; i < MD; i++) ref_mem[i] = 8'd0;
        for (int i = 0; i < BD; i++) twos[i*8 +: 8] = 8'd2;
        for (int i = 0; i < NC; i++) sixty_fours[i*8 +: 8] = 8'd64;

        // reset
        repeat (3) @(negedge clk);
        check_val("rst_web", bus.mvmu_web, 4'd3);
        check_val("rst_en", bus.mvmu_en, 1'b0);
        check_val("rst_res_valid", res_valid, 1'b0);
        check_val("rst_addr", bus.mvmu_addr, 16'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_val("post_rst_en", bus.mvmu_en, 1'b1);
        check_val("post_rst_web", bus.mvmu_web, 4'd3);
        check_val("post_rst_cmd_ready", cmd_ready, 1'b1);
        check_val("post_rst_w_ready", w_ready, 1'b0);
        check_val("post_rst_res_valid", res_valid, 1'b0);

        // load ramp pattern
        load_weights(0);
        check_val("mem_1009", dev_mem[1009], 8'd241);

        // ones x twos, with a 10-cycle stall on the result
        load_weights(1);
        do_compute("ones", twos, sixty_fours, 1'b0, NC + 3, 10);

        // reserved opcode is a no-op
        issue_cmd(2'd3, '0);
        check_val("rsvd_idle", cmd_ready, 1'b1);
        check_val("rsvd_web", bus.mvmu_web, 4'd3);
        check_val("rsvd_w_ready", w_ready, 1'b0);

        // clean then compute
        c0 = clean_cnt;
        issue_cmd(2'd0, '0);
        for (int i = 0; i < MD; i++) ref_mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        check_val("clean_cycles", clean_cnt - c0, 1);
        check_val("clean_idle", cmd_ready, 1'b1);
        do_compute("cleaned", rand_vec(), '0, 1'b0, NC + 3, 0);

        // random weights and vectors
        for (int t = 0; t < 3; t++) begin
            load_weights(2);
            vec = rand_vec();
            do_compute("rand", vec, ref_result(vec), 1'b0, NC + 3, $urandom_range(0, 4));
        end

        // reset in the middle of RUN, then a fresh compute
        issue_cmd(2'd2, rand_vec());
        repeat (10) @(negedge clk);
        check_val("mid_run_web", bus.mvmu_web, 4'd4);
        #2 rstn = 1'b0;
        #1;
        check_val("abort_web", bus.mvmu_web, 4'd3);
        check_val("abort_en", bus.mvmu_en, 1'b0);
        check_val("abort_idle", cmd_ready, 1'b1);
        check_val("abort_res_valid", res_valid, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        vec = rand_vec();
        do_compute("after_abort", vec, ref_result(vec), 1'b0, NC + 3, 2);

`ifdef MVMU_TIMEOUT_EN
        stuck = 1'b1;
        do_compute("timeout", rand_vec(), '0, 1'b1, TO + 1, 3);
        stuck = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_time_limit got=%0d exp=finished", cyc);
        $fatal(1);
    end
endmodule
